// File: rtl/func_ret_arbiter_mp.sv
// Multi-parent return arbiter: round-robin child returns into per-parent FIFOs.
// Optional per-parent stall counters with FUNC_RET_ARB_STALL_CNT_EN.
module func_ret_arbiter_mp #(
  parameter int PARENT     = 4,
  parameter int CHILD      = 8,
  parameter int RET_DW     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LOG_PARENT = (PARENT == 1) ? 1 : $clog2(PARENT),
  parameter int LOG_CHILD  = (CHILD == 1) ? 1 : $clog2(CHILD)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [CHILD-1:0]              child_retVld_i,
  output logic [CHILD-1:0]              child_retRdy_o,
  input  logic [RET_DW-1:0]             child_retDin_i [CHILD],
  input  logic [LOG_PARENT-1:0]         child_parentMod_i [CHILD],
  input  logic [PARENT-1:0]             parent_retFifo_pop_i,
  output logic [PARENT-1:0]             parent_retFifo_empty_n_o,
  output logic [RET_DW+LOG_CHILD-1:0]   parent_retFifo_dout_o [PARENT],
  output logic                          err_badParent_o
`ifdef FUNC_RET_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt_o [PARENT]
`endif
);

  localparam int LOG_D = $clog2(FIFO_DEPTH);
  localparam int EW    = RET_DW + LOG_CHILD;
  localparam logic [LOG_D:0] FULL = (LOG_D+1)'(FIFO_DEPTH);

  logic [EW-1:0]        r_mem [PARENT][FIFO_DEPTH];
  logic [LOG_D-1:0]     r_wr  [PARENT];
  logic [LOG_D-1:0]     r_rd  [PARENT];
  logic [LOG_D:0]       r_cnt [PARENT];
  logic [LOG_CHILD-1:0] r_rr  [PARENT];
  logic [PARENT-1:0]    r_empty_n;
  logic                 r_err;

  logic [PARENT-1:0]    w_gnt;
  logic [PARENT-1:0]    w_req_any;
  logic [PARENT-1:0]    w_pop;
  logic [LOG_CHILD-1:0] w_win [PARENT];
  logic [LOG_D:0]       w_cnt_nxt [PARENT];
  logic [CHILD-1:0]     w_rdy;
  logic                 w_bad;

  // Round-robin scan per parent; a full FIFO grants nobody.
  always_comb begin
    int w_idx;
    w_idx     = 0;
    w_rdy     = '0;
    w_gnt     = '0;
    w_req_any = '0;
    w_bad     = 1'b0;
    for (int p = 0; p < PARENT; p++) begin
      w_win[p] = '0;
    end
    for (int c = 0; c < CHILD; c++) begin
      if (child_retVld_i[c] &&
          int'(child_parentMod_i[c]) >= PARENT) begin
        w_bad = 1'b1;
      end
    end
    for (int p = 0; p < PARENT; p++) begin
      for (int k = 0; k < CHILD; k++) begin
        w_idx = (int'(r_rr[p]) + k) % CHILD;
        if (child_retVld_i[w_idx] &&
            int'(child_parentMod_i[w_idx]) == p) begin
          w_req_any[p] = 1'b1;
          if (!w_gnt[p] && r_cnt[p] != FULL) begin
            w_gnt[p]     = 1'b1;
            w_win[p]     = LOG_CHILD'(w_idx);
            w_rdy[w_idx] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PARENT; p++) begin
      w_pop[p]     = parent_retFifo_pop_i[p] & r_empty_n[p];
      w_cnt_nxt[p] = r_cnt[p];
      unique case ({w_gnt[p], w_pop[p]})
        2'b10:   w_cnt_nxt[p] = r_cnt[p] + 1'b1;
        2'b01:   w_cnt_nxt[p] = r_cnt[p] - 1'b1;
        default: w_cnt_nxt[p] = r_cnt[p];
      endcase
      parent_retFifo_dout_o[p] = r_mem[p][r_rd[p]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_empty_n <= '0;
      r_err     <= 1'b0;
      for (int p = 0; p < PARENT; p++) begin
        r_wr[p]  <= '0;
        r_rd[p]  <= '0;
        r_cnt[p] <= '0;
        r_rr[p]  <= '0;
      end
    end else begin
      r_err <= w_bad;
      for (int p = 0; p < PARENT; p++) begin
        r_cnt[p]     <= w_cnt_nxt[p];
        r_empty_n[p] <= (w_cnt_nxt[p] != '0);
        if (w_pop[p]) begin
          r_rd[p] <= r_rd[p] + 1'b1;
        end
        if (w_gnt[p]) begin
          r_wr[p] <= r_wr[p] + 1'b1;
          r_rr[p] <= (int'(w_win[p]) == CHILD - 1) ?
                     '0 : w_win[p] + 1'b1;
        end
      end
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PARENT; p++) begin
      if (w_gnt[p]) begin
        r_mem[p][r_wr[p]] <=
          {w_win[p], child_retDin_i[w_win[p]]};
      end
    end
  end

`ifdef FUNC_RET_ARB_STALL_CNT_EN
  logic [15:0] r_stall [PARENT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PARENT; p++) begin
        r_stall[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PARENT; p++) begin
        if (w_req_any[p] && r_cnt[p] == FULL &&
            r_stall[p] != 16'hFFFF) begin
          r_stall[p] <= r_stall[p] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall;
`endif

  assign child_retRdy_o           = w_rdy;
  assign parent_retFifo_empty_n_o = r_empty_n;
  assign err_badParent_o          = r_err;

endmodule

// File: tb/tb_func_ret_arbiter_mp.sv
// Directed bench for func_ret_arbiter_mp (PARENT=4 and PARENT=3 builds).
// Stall counter checks compile in with FUNC_RET_ARB_STALL_CNT_EN.
module tb_func_ret_arbiter_mp;

  logic        clk = 1'b0;
  logic        rstn;

  logic [7:0]  vld;
  logic [7:0]  rdy;
  logic [31:0] din [8];
  logic [1:0]  pm [8];
  logic [3:0]  pop;
  logic [3:0]  en;
  logic [34:0] dout [4];
  logic        err;

  logic [7:0]  b_vld;
  logic [7:0]  b_rdy;
  logic [1:0]  b_pm [8];
  logic [2:0]  b_pop;
  logic [2:0]  b_en;
  logic [34:0] b_dout [3];
  logic        b_err;

`ifdef FUNC_RET_ARB_STALL_CNT_EN
  logic [15:0] stall [4];
  logic [15:0] b_stall [3];
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  func_ret_arbiter_mp u_dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .child_retVld_i           (vld),
    .child_retRdy_o           (rdy),
    .child_retDin_i           (din),
    .child_parentMod_i        (pm),
    .parent_retFifo_pop_i     (pop),
    .parent_retFifo_empty_n_o (en),
    .parent_retFifo_dout_o    (dout),
    .err_badParent_o          (err)
`ifdef FUNC_RET_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o              (stall)
`endif
  );

  func_ret_arbiter_mp #(.PARENT(3)) u_b (
    .clk                      (clk),
    .rstn                     (rstn),
    .child_retVld_i           (b_vld),
    .child_retRdy_o           (b_rdy),
    .child_retDin_i           (din),
    .child_parentMod_i        (b_pm),
    .parent_retFifo_pop_i     (b_pop),
    .parent_retFifo_empty_n_o (b_en),
    .parent_retFifo_dout_o    (b_dout),
    .err_badParent_o          (b_err)
`ifdef FUNC_RET_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o              (b_stall)
`endif
  );

  typedef struct {
    logic [7:0]  vld;
    logic [15:0] pm;
    logic [3:0]  pop;
    logic [7:0]  rdy;
    logic [3:0]  en;
    logic        chk;
    int          p;
    logic [34:0] dout;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    vld   = '0;
    pop   = '0;
    b_vld = '0;
    b_pop = '0;
    for (int c = 0; c < 8; c++) begin
      pm[c]   = '0;
      b_pm[c] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_pm(input logic [15:0] v);
    for (int c = 0; c < 8; c++) pm[c] = v[2*c +: 2];
  endtask

  initial begin
    for (int c = 0; c < 8; c++) begin
      din[c] = (c == 3) ? 32'hCAFE : 32'hD000 + c;
    end
    tv[0]  = '{8'h00, 16'h0000, 4'h0, 8'h00, 4'h0, 0, 0, 35'h0};
    tv[1]  = '{8'h08, 16'h0040, 4'h0, 8'h08, 4'h2, 1, 1,
               {3'd3, 32'hCAFE}};
    tv[2]  = '{8'h00, 16'h0000, 4'h2, 8'h00, 4'h0, 0, 0, 35'h0};
    tv[3]  = '{8'h00, 16'h0000, 4'h2, 8'h00, 4'h0, 0, 0, 35'h0};
    tv[4]  = '{8'h25, 16'h0000, 4'h0, 8'h01, 4'h1, 1, 0,
               {3'd0, 32'hD000}};
    tv[5]  = '{8'h25, 16'h0000, 4'h0, 8'h04, 4'h1, 1, 0,
               {3'd0, 32'hD000}};
    tv[6]  = '{8'h25, 16'h0000, 4'h0, 8'h20, 4'h1, 1, 0,
               {3'd0, 32'hD000}};
    tv[7]  = '{8'h25, 16'h0000, 4'h0, 8'h01, 4'h1, 1, 0,
               {3'd0, 32'hD000}};
    tv[8]  = '{8'h25, 16'h0000, 4'h0, 8'h00, 4'h1, 1, 0,
               {3'd0, 32'hD000}};
    tv[9]  = '{8'h25, 16'h0000, 4'h1, 8'h00, 4'h1, 1, 0,
               {3'd2, 32'hD002}};
    tv[10] = '{8'h25, 16'h0000, 4'h0, 8'h04, 4'h1, 1, 0,
               {3'd2, 32'hD002}};
    tv[11] = '{8'h00, 16'h0000, 4'h1, 8'h00, 4'h1, 1, 0,
               {3'd5, 32'hD005}};

    do_reset();
    #1;
    chk("rst_en", 64'(en), 64'h0);
    chk("rst_rdy", 64'(rdy), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_b_err", 64'(b_err), 64'h0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vld = tv[i].vld;
      set_pm(tv[i].pm);
      pop = tv[i].pop;
      #1;
      chk($sformatf("v%0d_rdy", i), 64'(rdy), 64'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), 64'(en), 64'(tv[i].en));
      if (tv[i].chk) begin
        chk($sformatf("v%0d_dout", i),
            64'(dout[tv[i].p]), 64'(tv[i].dout));
      end
    end

    // Distinct parents accepted in the same cycle
    @(negedge clk);
    do_reset();
    vld = 8'h03;
    set_pm(16'h000C);
    #1;
    chk("par_rdy", 64'(rdy), 64'h03);
    @(posedge clk);
    #1;
    chk("par_en", 64'(en), 64'h9);
    chk("par_d0", 64'(dout[0]), 64'({3'd0, 32'hD000}));
    chk("par_d3", 64'(dout[3]), 64'({3'd1, 32'hD001}));

    // Fill parent 2, then pop and request together: no bypass
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vld = 8'h02;
      set_pm(16'h0008);
      #1;
      chk($sformatf("f2_rdy%0d", i), 64'(rdy), 64'h02);
    end
    @(negedge clk);
    pop = 4'h4;
    #1;
    chk("f2_nobyp", 64'(rdy), 64'h00);
    @(posedge clk);
    #1;
    chk("f2_en", 64'(en[2]), 64'h1);
    @(negedge clk);
    pop = 4'h0;
    #1;
    chk("f2_next", 64'(rdy), 64'h02);
    @(posedge clk);
    @(negedge clk);
    vld = '0;

    // Bad parent on the 3-parent instance
    b_vld   = 8'h05;
    b_pm[0] = 2'd3;
    b_pm[2] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bad_rdy%0d", i), 64'(b_rdy), 64'h04);
      @(posedge clk);
      #1;
      chk($sformatf("bad_err%0d", i), 64'(b_err), 64'h1);
      @(negedge clk);
    end
    b_vld = '0;
    @(posedge clk);
    #1;
    chk("bad_clr", 64'(b_err), 64'h0);
    chk("bad_en", 64'(b_en), 64'h4);

`ifdef FUNC_RET_ARB_STALL_CNT_EN
    @(negedge clk);
    do_reset();
    vld = 8'h01;
    set_pm(16'h0000);
    repeat (14) @(posedge clk);
    #1;
    chk("stall10", 64'(stall[0]), 64'd10);
    chk("stall_p1", 64'(stall[1]), 64'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", 64'(stall[0]), 64'hFFFF);
    @(negedge clk);
    vld = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
